if_branch_stage: RTL and testbench

- Instruction-fetch stage of the five-stage pipeline. Owns the PC register and the IF/ID pipeline register.
- Consumes the shifted branch offset from the sign-extend/shift-left-2 unit in ID, and redirects the PC on taken branches and jumps.
- Supports hazard-unit stalls, and inserts one bubble into IF/ID on every redirect.

---
 rtl/if_branch_stage_pkg.sv | 33 +++
 rtl/if_branch_stage_pc_next_mux.sv | 53 +++++
 rtl/if_branch_stage.sv | 79 +++++++
 tb/tb_if_branch_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/if_branch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: NOP encoding, reset PC,
// PC increment and the field positions used to build jump targets.
package if_branch_stage_pkg;

  // All-zero word is the NOP (sll $0,$0,0); it fills IF/ID on reset and flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default PC loaded on reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential fetch advances by one 32-bit word.
  localparam int PC_INCR = 4;

  // Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  localparam int JUMP_HI_MSB = 31;
  localparam int JUMP_HI_LSB = 28;
  localparam int JUMP_IDX_W  = 26;

  // Source selected for the next PC.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_SEQ    = 2'd3
  } next_sel_e;

  // Build a pseudo-direct jump target from the upper PC bits and the index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [JUMP_IDX_W-1:0] index);
    return {pc_plus4[JUMP_HI_MSB:JUMP_HI_LSB], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_branch_stage_pc_next_mux.sv
// Combinational next-PC selection. Priority: stall holds the PC, then jump,
// then taken branch, then sequential fetch. A redirect is reported only
// when it is actually applied (not while stalled).
module pc_next_mux
  import if_branch_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      pc,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  branch_taken,
  input  logic [WIDTH-1:0]      branch_offset,
  input  logic [JUMP_IDX_W-1:0] jump_index,
  input  logic [WIDTH-1:0]      id_pc_plus4,
  output logic [WIDTH-1:0]      next_pc,
  output logic [WIDTH-1:0]      pc_plus4,
  output logic                  redirect
);

  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  next_sel_e        sel;

  // Target arithmetic: all modulo 2^WIDTH, no overflow detection.
  always_comb begin
    pc_plus4   = pc + WIDTH'(PC_INCR);
    branch_tgt = id_pc_plus4 + branch_offset;
    jump_tgt   = WIDTH'(jump_target(32'(id_pc_plus4), jump_index));
  end

  // Pick the next-PC source; a stalled redirect is dropped and re-presented
  // later by the hazard unit.
  always_comb begin
    sel = SEL_SEQ;
    if (stall)             sel = SEL_HOLD;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    redirect = (jump | branch_taken) & ~stall;
  end

  // Route the selected source to next_pc.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_JUMP:   next_pc = jump_tgt;
      SEL_BRANCH: next_pc = branch_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_branch_stage.sv
// Instruction-fetch stage: PC register, instruction memory address and the
// IF/ID pipeline register. Every applied redirect squashes the instruction
// fetched in the same cycle, leaving one bubble in IF/ID.
//
// Flow control: stall=1 freezes both PC and IF/ID for that cycle and any
// redirect presented alongside it is ignored; if_id_valid=0 marks a bubble
// that ID must not act on.
module if_branch_stage
  import if_branch_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [WIDTH-1:0]      branch_offset,
  input  logic                  jump,
  input  logic [JUMP_IDX_W-1:0] jump_index,
  input  logic [WIDTH-1:0]      id_pc_plus4,
  input  logic [WIDTH-1:0]      imem_rdata,
  output logic [WIDTH-1:0]      imem_addr,
  output logic [WIDTH-1:0]      if_id_instr,
  output logic [WIDTH-1:0]      if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  redirect
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] next_pc;

  pc_next_mux #(.WIDTH(WIDTH)) u_pc_next_mux (
    .pc            (pc),
    .stall         (stall),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .id_pc_plus4   (id_pc_plus4),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect)
  );

  // Instruction memory is read combinationally at the current PC.
  always_comb begin
    imem_addr = pc;
  end

  // PC register; the mux already folds in the stall hold.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  // IF/ID register: hold on stall, flush to a bubble on redirect, else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr    <= WIDTH'(NOP_INSTR);
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (stall) begin
      if_id_instr    <= if_id_instr;
      if_id_pc_plus4 <= if_id_pc_plus4;
      if_id_valid    <= if_id_valid;
    end else if (redirect) begin
      if_id_instr    <= WIDTH'(NOP_INSTR);
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else begin
      if_id_instr    <= imem_rdata;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_branch_stage.sv
// Directed bench for if_branch_stage. Instruction memory returns addr|1.
// Expected IF/ID contents are pushed when a cycle's stimulus is driven and
// popped for comparison after the clock edge.
module tb_if_branch_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          branch_taken;
  logic [W-1:0]  branch_offset;
  logic          jump;
  logic [25:0]   jump_index;
  logic [W-1:0]  id_pc_plus4;
  logic [W-1:0]  imem_rdata;
  logic [W-1:0]  imem_addr;
  logic [W-1:0]  if_id_instr;
  logic [W-1:0]  if_id_pc_plus4;
  logic          if_id_valid;
  logic          redirect;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_instr, last_pp4, last_valid;

  if_branch_stage #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .id_pc_plus4    (id_pc_plus4),
    .imem_rdata     (imem_rdata),
    .imem_addr      (imem_addr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .redirect       (redirect)
  );

  // Clock and instruction memory model.
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr | 32'h1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bt, input logic jp,
                       input logic [W-1:0] off, input logic [W-1:0] pp4,
                       input logic [25:0] idx);
    stall         = st;
    branch_taken  = bt;
    jump          = jp;
    branch_offset = off;
    id_pc_plus4   = pp4;
    jump_index    = idx;
  endtask

  // kind: "F" fetch, "B" bubble, "H" hold. Checks comb outputs, pushes the
  // expected IF/ID values, clocks, then pops and compares.
  task automatic cycle(input string tag, input logic [W-1:0] exp_addr,
                       input logic exp_red, input string kind);
    logic [W-1:0] e_i, e_p, e_v;
    #1;
    chk({tag, ".imem_addr"}, imem_addr, exp_addr);
    chk({tag, ".redirect"}, W'(redirect), W'(exp_red));
    if (kind == "F") begin
      e_i = exp_addr | 32'h1; e_p = exp_addr + 32'd4; e_v = 1;
    end else if (kind == "B") begin
      e_i = '0; e_p = '0; e_v = 0;
    end else begin
      e_i = last_instr; e_p = last_pp4; e_v = last_valid;
    end
    exp_q.push_back(e_i); exp_q.push_back(e_p); exp_q.push_back(e_v);
    last_instr = e_i; last_pp4 = e_p; last_valid = e_v;
    @(posedge clk); #1;
    chk({tag, ".if_id_instr"}, if_id_instr, exp_q.pop_front());
    chk({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, exp_q.pop_front());
    chk({tag, ".if_id_valid"}, W'(if_id_valid), exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    last_instr = '0; last_pp4 = '0; last_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset.imem_addr", imem_addr, 32'h0);
    chk("reset.if_id_instr", if_id_instr, 32'h0);
    chk("reset.if_id_pc_plus4", if_id_pc_plus4, 32'h0);
    chk("reset.if_id_valid", W'(if_id_valid), 32'h0);
    rst = 1'b0;

    // Free run with don't-care offset/index values.
    drive(0, 0, 0, $urandom, $urandom, 26'($urandom_range(0, 26'h3FF_FFFF)));
    cycle("run0", 32'h0, 0, "F");
    cycle("run1", 32'h4, 0, "F");
    cycle("run2", 32'h8, 0, "F");
    cycle("run3", 32'hC, 0, "F");

    // Forward branch: 0x10 + 0x20.
    drive(0, 1, 0, 32'h20, 32'h10, '0);
    cycle("fwd_br", 32'h10, 1, "B");
    drive(0, 0, 0, 32'h20, 32'h10, '0);
    cycle("fwd_tgt", 32'h30, 0, "F");
    cycle("fwd_seq", 32'h34, 0, "F");

    // Backward branch: 0x40 - 0x10.
    drive(0, 1, 0, 32'hFFFF_FFF0, 32'h40, '0);
    cycle("bwd_br", 32'h38, 1, "B");
    drive(0, 0, 0, '0, '0, '0);
    cycle("bwd_tgt", 32'h30, 0, "F");

    // Jump beats branch, then a back-to-back jump while ID holds a bubble.
    drive(0, 1, 1, 32'h20, 32'h9000_0004, 26'h000_0100);
    cycle("jmp_vs_br", 32'h34, 1, "B");
    drive(0, 0, 1, 32'h20, 32'h9000_0004, 26'h000_0200);
    cycle("jmp_b2b", 32'h9000_0400, 1, "B");
    drive(0, 0, 0, '0, '0, '0);
    cycle("jmp_tgt", 32'h9000_0800, 0, "F");

    // Stall with branch pending: everything frozen, no redirect.
    drive(1, 1, 0, 32'h20, 32'h10, '0);
    for (int i = 0; i < 3; i++) cycle("stall_br", 32'h9000_0804, 0, "H");
    drive(0, 1, 0, 32'h20, 32'h10, '0);
    cycle("post_stall_br", 32'h9000_0804, 1, "B");
    drive(0, 0, 0, '0, '0, '0);
    cycle("post_stall_tgt", 32'h30, 0, "F");

    // Wrap: jump to 0xFFFFFFFC, then sequential fetch wraps to 0.
    drive(0, 0, 1, '0, 32'hF000_0000, 26'h3FF_FFFF);
    cycle("wrap_jmp", 32'h34, 1, "B");
    drive(0, 0, 0, '0, '0, '0);
    cycle("wrap_top", 32'hFFFF_FFFC, 0, "F");
    cycle("wrap_zero", 32'h0, 0, "F");

    // Reset during stall+jump.
    rst = 1'b1;
    drive(1, 0, 1, '0, 32'h9000_0004, 26'h000_0100);
    @(posedge clk); #1;
    chk("rst_stall.imem_addr", imem_addr, 32'h0);
    chk("rst_stall.if_id_valid", W'(if_id_valid), 32'h0);
    chk("rst_stall.if_id_instr", if_id_instr, 32'h0);

    // Reset during an applied redirect.
    drive(0, 1, 1, 32'h20, 32'h9000_0004, 26'h000_0100);
    @(posedge clk); #1;
    chk("rst_redir.imem_addr", imem_addr, 32'h0);
    chk("rst_redir.if_id_pc_plus4", if_id_pc_plus4, 32'h0);
    chk("rst_redir.if_id_valid", W'(if_id_valid), 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    last_instr = '0; last_pp4 = '0; last_valid = '0;
    cycle("after_rst0", 32'h0, 0, "F");
    cycle("after_rst1", 32'h4, 0, "F");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule
